// File: rtl/rr_arb4_if.sv
// rr_arb4_if: request side and shared downstream channel of the four-way
// round-robin arbiter. The master side is the requesters plus consumer,
// the slave side is the arbiter itself.
interface rr_arb4_if #(
  parameter int N = 8
);
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [N-1:0] req_data0;
  logic [N-1:0] req_data1;
  logic [N-1:0] req_data2;
  logic [N-1:0] req_data3;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  modport master (
    output req_valid, req_last, req_data0, req_data1, req_data2, req_data3,
    output out_ready,
    input  req_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_last, req_data0, req_data1, req_data2, req_data3,
    input  out_ready,
    output req_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with packet locking.
// A winner is registered in IDLE and keeps the channel until its last beat
// is accepted; the pointer then moves one past that winner so it ends up
// at lowest priority for the next arbitration round.
module rr_arb4 #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       reset,
  rr_arb4_if.slave   bus,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   ptr;
  logic [1:0]   ptr_next;
  logic [1:0]   sel_next;
  logic [3:0]   grant_next;
  logic [1:0]   winner;
  logic [1:0]   cand;
  logic         any_req;
  logic         grantee_valid;
  logic         grantee_last;
  logic         xfer_last;
  logic [N-1:0] mux_data;

  // Datapath mux: out_data follows sel in every state, unknown select propagates x
  always_comb begin
    case (sel)
      2'd0:    mux_data = bus.req_data0;
      2'd1:    mux_data = bus.req_data1;
      2'd2:    mux_data = bus.req_data2;
      2'd3:    mux_data = bus.req_data3;
      default: mux_data = 'x;
    endcase
  end

  // Rotating priority search: scanning from farthest to nearest offset lets
  // the requester closest to ptr overwrite the others and win
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    cand    = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (bus.req_valid[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  assign grantee_valid = bus.req_valid[sel];
  assign grantee_last  = bus.req_last[sel];
  assign xfer_last     = (state == LOCKED) & grantee_valid & grantee_last & bus.out_ready;
  assign bus.out_data  = mux_data;
  assign busy          = (state == LOCKED);

  // Channel handshake is only opened to the grantee while a packet holds the lock
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.req_ready = 4'b0000;
    if (state == LOCKED) begin
      bus.out_valid      = grantee_valid;
      bus.out_last       = grantee_valid & grantee_last;
      bus.req_ready[sel] = bus.out_ready;
    end
  end

  // Next-state logic: arbitrate in IDLE, release on the accepted last beat
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          sel_next   = winner;
          grant_next = 4'b0001 << winner;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer_last) begin
          ptr_next   = sel + 2'd1;
          grant_next = 4'b0000;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase
  end

  // Arbitration registers; reset abandons any packet in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      grant <= 4'b0000;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      sel   <= sel_next;
      grant <= grant_next;
    end
  end

endmodule
